// File: rtl/cb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cb_pkg : shared defaults and index-width helper for counter_bank
// Rev 1.0
// ----------------------------------------------------------------------------
package cb_pkg;

    localparam int CB_N_CNT = 4;
    localparam int CB_DT_SZ = 4;

    // Slot index width, never narrower than one bit so a single slot still has a port.
    function automatic int cb_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_bank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_bank_if : customer offer handshake into counter_bank
// Rev 1.0
// ----------------------------------------------------------------------------
interface counter_bank_if
    import cb_pkg::*;
#(
    parameter int N_CNT = CB_N_CNT,
    parameter int DT_SZ = CB_DT_SZ
) ();

    localparam int IDX_W = cb_idx_w(N_CNT);

    logic             in_vld;
    logic             in_rdy;
    logic [DT_SZ-1:0] in_num;
    logic [DT_SZ-1:0] in_time;
    logic             acc;
    logic [IDX_W-1:0] asg_idx;

    modport master (
        output in_vld, in_num, in_time,
        input  in_rdy, acc, asg_idx
    );

    modport slave (
        input  in_vld, in_num, in_time,
        output in_rdy, acc, asg_idx
    );

endinterface
`default_nettype wire

// File: rtl/srv_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srv_slot : one service slot holding a customer and its countdown
// Rev 1.0
// ----------------------------------------------------------------------------
module srv_slot
    import cb_pkg::*;
#(
    parameter int DT_SZ = CB_DT_SZ
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             ld,
    input  wire logic [DT_SZ-1:0] ld_num,
    input  wire logic [DT_SZ-1:0] ld_time,
    input  wire logic             rel,
    input  wire logic             hold,
    output logic                  busy,
    output logic      [DT_SZ-1:0] num,
    output logic      [DT_SZ-1:0] rem,
    output logic                  done
);

    logic             r_busy;
    logic [DT_SZ-1:0] r_num;
    logic [DT_SZ-1:0] r_rem;
    logic             r_done;
    logic [DT_SZ-1:0] w_ld_rem;

    // A zero service time still occupies the slot for one cycle.
    assign w_ld_rem = (ld_time == '0) ? DT_SZ'(1) : ld_time;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_num  <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy && rel) begin
                r_busy <= 1'b0;
                r_num  <= '0;
                r_rem  <= '0;
            end else if (!r_busy && ld) begin
                r_busy <= 1'b1;
                r_num  <= ld_num;
                r_rem  <= w_ld_rem;
            end else if (r_busy && !hold) begin
                if (r_rem == DT_SZ'(1)) begin
                    r_busy <= 1'b0;
                    r_num  <= '0;
                    r_rem  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_rem  <= r_rem - DT_SZ'(1);
                end
            end
        end
    end

    assign busy = r_busy;
    assign num  = r_num;
    assign rem  = r_rem;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_bank : bank of N_CNT service slots fed lowest-free-first
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_bank
    import cb_pkg::*;
#(
    parameter int N_CNT = CB_N_CNT,
    parameter int DT_SZ = CB_DT_SZ,
    localparam int IDX_W = cb_idx_w(N_CNT),
    localparam int CNT_W = $clog2(N_CNT + 1)
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    counter_bank_if.slave               bus,
    input  wire logic                   hold,
    input  wire logic [N_CNT-1:0]       rel,
    output logic      [N_CNT-1:0]       busy,
    output logic      [N_CNT*DT_SZ-1:0] num,
    output logic      [N_CNT*DT_SZ-1:0] rem,
    output logic      [N_CNT-1:0]       done,
    output logic      [CNT_W-1:0]       free_cnt
);

    logic [IDX_W-1:0] w_sel;
    logic [CNT_W-1:0] w_free;
    logic             w_rdy;
    logic             w_acc;

    // Selection looks only at registered busy, so a slot freed this cycle waits one cycle.
    always_comb begin
        w_sel = '0;
        for (int i = N_CNT - 1; i >= 0; i--) begin
            if (!busy[i]) w_sel = IDX_W'(i);
        end
    end

    always_comb begin
        w_free = '0;
        for (int i = 0; i < N_CNT; i++) begin
            w_free = w_free + CNT_W'(!busy[i]);
        end
    end

    assign w_rdy       = ~&busy;
    assign w_acc       = bus.in_vld & w_rdy;
    assign bus.in_rdy  = w_rdy;
    assign bus.acc     = w_acc;
    assign bus.asg_idx = w_acc ? w_sel : '0;
    assign free_cnt    = w_free;

    for (genvar i = 0; i < N_CNT; i++) begin : g_slot
        srv_slot #(
            .DT_SZ (DT_SZ)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld      (w_acc && (w_sel == IDX_W'(i))),
            .ld_num  (bus.in_num),
            .ld_time (bus.in_time),
            .rel     (rel[i]),
            .hold    (hold),
            .busy    (busy[i]),
            .num     (num[i*DT_SZ +: DT_SZ]),
            .rem     (rem[i*DT_SZ +: DT_SZ]),
            .done    (done[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_counter_bank : directed self-checking bench for counter_bank (4 slots x 4 bits)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_counter_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  rel = 4'b0;
    logic [3:0]  busy;
    logic [15:0] num;
    logic [15:0] rem;
    logic [3:0]  done;
    logic [2:0]  free_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    counter_bank_if #(.N_CNT(4), .DT_SZ(4)) bif ();

    counter_bank #(.N_CNT(4), .DT_SZ(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bif.slave),
        .hold     (hold),
        .rel      (rel),
        .busy     (busy),
        .num      (num),
        .rem      (rem),
        .done     (done),
        .free_cnt (free_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rem_of(input int i);
        return rem[i*4 +: 4];
    endfunction

    function automatic logic [3:0] num_of(input int i);
        return num[i*4 +: 4];
    endfunction

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [3:0] n, input logic [3:0] t);
        bif.in_vld  = v;
        bif.in_num  = n;
        bif.in_time = t;
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        bif.in_vld  = 1'b0;
        bif.in_num  = '0;
        bif.in_time = '0;
        #2;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_num", 32'(num), 32'h0);
        check("rst_rem", 32'(rem), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rdy", 32'(bif.in_rdy), 32'h1);
        check("rst_free", 32'(free_cnt), 32'd4);
        tick();
        rst_n = 1'b1;
        #1;

        // Single customer, time 3
        offer(1'b1, 4'd5, 4'd3);
        check("s1_acc", 32'(bif.acc), 32'h1);
        check("s1_idx", 32'(bif.asg_idx), 32'h0);
        tick();
        offer(1'b0, 4'd0, 4'd0);
        check("s1_busy1", 32'(busy), 32'b0001);
        check("s1_num1", 32'(num_of(0)), 32'd5);
        check("s1_rem1", 32'(rem_of(0)), 32'd3);
        tick();
        check("s1_rem2", 32'(rem_of(0)), 32'd2);
        tick();
        check("s1_rem3", 32'(rem_of(0)), 32'd1);
        check("s1_busy3", 32'(busy), 32'b0001);
        tick();
        check("s1_busy4", 32'(busy), 32'b0000);
        check("s1_done4", 32'(done), 32'b0001);
        check("s1_num4", 32'(num_of(0)), 32'd0);
        tick();
        check("s1_done5", 32'(done), 32'b0000);

        // Five back-to-back offers, time 9
        do_reset();
        for (int k = 0; k < 4; k++) begin
            offer(1'b1, 4'(k + 1), 4'd9);
            check("s2_free", 32'(free_cnt), 32'(4 - k));
            check("s2_idx", 32'(bif.asg_idx), 32'(k));
            tick();
        end
        offer(1'b1, 4'd5, 4'd9);
        check("s2_free0", 32'(free_cnt), 32'd0);
        check("s2_rdy0", 32'(bif.in_rdy), 32'h0);
        check("s2_acc0", 32'(bif.acc), 32'h0);
        begin
            int waited = 0;
            while (!bif.in_rdy && waited < 20) begin
                tick();
                waited++;
            end
            check("s2_wait", 32'(waited), 32'd6);
        end
        check("s2_acc5", 32'(bif.acc), 32'h1);
        check("s2_idx5", 32'(bif.asg_idx), 32'h0);
        check("s2_done0", 32'(done), 32'b0001);
        tick();
        offer(1'b0, 4'd0, 4'd0);
        check("s2_num0", 32'(num_of(0)), 32'd5);
        check("s2_rem0", 32'(rem_of(0)), 32'd9);

        // Hold freezes slot 2 at rem 6
        do_reset();
        offer(1'b1, 4'd1, 4'd15); tick();
        offer(1'b1, 4'd2, 4'd15); tick();
        offer(1'b1, 4'd3, 4'd8);  tick();
        offer(1'b0, 4'd0, 4'd0);
        check("s3_rem8", 32'(rem_of(2)), 32'd8);
        tick();
        tick();
        check("s3_rem6", 32'(rem_of(2)), 32'd6);
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("s3_hold_rem", 32'(rem_of(2)), 32'd6);
            check("s3_hold_done", 32'(done), 32'h0);
        end
        hold = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("s3_nodone", 32'(done), 32'h0);
        end
        check("s3_rem1", 32'(rem_of(2)), 32'd1);
        tick();
        check("s3_done", 32'(done), 32'b0100);
        check("s3_busy", 32'(busy), 32'b0011);

        // Forced release of a busy slot and of an idle slot
        do_reset();
        offer(1'b1, 4'd4, 4'd15); tick();
        offer(1'b1, 4'd6, 4'd7);  tick();
        offer(1'b0, 4'd0, 4'd0);
        check("s4_rem7", 32'(rem_of(1)), 32'd7);
        rel = 4'b0010;
        tick();
        check("s4_busy", 32'(busy), 32'b0001);
        check("s4_num1", 32'(num_of(1)), 32'd0);
        check("s4_rem1", 32'(rem_of(1)), 32'd0);
        check("s4_done", 32'(done), 32'h0);
        rel = 4'b1000;
        tick();
        rel = 4'b0000;
        check("s4_idle_busy", 32'(busy), 32'b0001);
        check("s4_idle_rem0", 32'(rem_of(0)), 32'd12);
        check("s4_idle_num3", 32'(num_of(3)), 32'd0);

        // Slot 0 completing does not free it until the next cycle
        do_reset();
        offer(1'b1, 4'd1, 4'd5);  tick();
        offer(1'b1, 4'd2, 4'd15); tick();
        offer(1'b1, 4'd3, 4'd15); tick();
        offer(1'b1, 4'd4, 4'd15); tick();
        offer(1'b1, 4'd9, 4'd2);
        check("s5_rdy_c4", 32'(bif.in_rdy), 32'h0);
        tick();
        check("s5_rem1", 32'(rem_of(0)), 32'd1);
        check("s5_rdy_t", 32'(bif.in_rdy), 32'h0);
        check("s5_acc_t", 32'(bif.acc), 32'h0);
        tick();
        check("s5_acc_t1", 32'(bif.acc), 32'h1);
        check("s5_idx_t1", 32'(bif.asg_idx), 32'h0);
        tick();
        offer(1'b0, 4'd0, 4'd0);
        check("s5_num0", 32'(num_of(0)), 32'd9);

        // Asynchronous reset mid-service, then zero-time customer
        do_reset();
        offer(1'b1, 4'd1, 4'd10); tick();
        offer(1'b1, 4'd2, 4'd10); tick();
        offer(1'b1, 4'd3, 4'd10); tick();
        offer(1'b0, 4'd0, 4'd0);
        check("s6_busy3", 32'(busy), 32'b0111);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_arst_busy", 32'(busy), 32'h0);
        check("s6_arst_num", 32'(num), 32'h0);
        check("s6_arst_rem", 32'(rem), 32'h0);
        check("s6_arst_done", 32'(done), 32'h0);
        check("s6_arst_free", 32'(free_cnt), 32'd4);
        tick();
        rst_n = 1'b1;
        #1;
        check("s6_done_after", 32'(done), 32'h0);
        check("s6_rdy", 32'(bif.in_rdy), 32'h1);
        offer(1'b1, 4'd7, 4'd0);
        check("s6_acc", 32'(bif.acc), 32'h1);
        tick();
        offer(1'b0, 4'd0, 4'd0);
        check("s6_rem1", 32'(rem_of(0)), 32'd1);
        check("s6_done_ld", 32'(done), 32'h0);
        tick();
        check("s6_done", 32'(done), 32'b0001);
        check("s6_busy0", 32'(busy), 32'b0000);
        tick();
        check("s6_done_end", 32'(done), 32'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
